pilot_insert_buffer: RTL and testbench
======================================

Name: pilot_insert_buffer

Overview:
- Input-side storage for the OFDM pilot-insertion stage. Combines two parts:
  - a synchronous single-clock FIFO holding {tlast, symb_last, 32-bit IQ sample} words from the modulator;
  - a 127-entry, 1-bit pilot-polarity ROM indexed by OFDM symbol number.
- The pilot-insertion FSM reads samples through this block and looks up the polarity of each symbol's pilot subcarriers.

Parameters:
- DATA_WIDTH, 34, FIFO word width ({tlast, symb_last, data[31:0]}).
- DEPTH, 64, FIFO depth in words; must be a power of two and at least 2.
- CNT_WIDTH, 7, width of data_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  single clock; all logic samples on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data; registered.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- data_count  out  CNT_WIDTH  number of words stored, 0..DEPTH.
- pilot_addr  in  7  ROM address (symbol index).
- pilot_dout  out  1  pilot polarity; 1 = negative pilot (-1), 0 = positive pilot (+1).

Behaviour:
- Reset, sampled while rst=0 at a clock edge:
  - read and write pointers cleared; data_count=0;
  - empty=1, full=0;
  - dout=0, pilot_dout=0.
  - Reset has priority over any wr_en or rd_en in the same cycle.
  - Reset mid-operation discards all stored words.
- Write: wr_en=1 and full=0 stores din at the write pointer; the pointer advances modulo DEPTH. wr_en while full is ignored (no overwrite, no pointer change).
- Read (standard mode, not first-word-fall-through):
  - rd_en=1 and empty=0 pops the word at the read pointer into the dout register, visible the cycle after rd_en.
  - rd_en while empty is ignored; dout holds its previous value.
  - dout holds its last read value until the next successful read.
- Simultaneous read and write with 0 < count < DEPTH: both occur and the count is unchanged.
  - When empty: only the write occurs; the word is not readable until the following cycle.
  - When full: only the read occurs; the write is dropped.
- Flags:
  - full and empty are registered and correct in the cycle after the operation that changed the count;
  - data_count tracks them exactly; full = (data_count == DEPTH), empty = (data_count == 0).
- Word ordering is strict FIFO; the pointers wrap around with no gap or duplication.
- Pilot ROM:
  - synchronous read with 1-cycle latency: pilot_dout at edge N+1 = ROM[pilot_addr sampled at edge N];
  - contents ROM[n], n=0..126, are the output of the 7-bit scrambler x^7+x^4+1 seeded all-ones;
  - generation: state s7..s1 = 1111111; per step, bit = s7 XOR s4, then shift left inserting bit at s1; ROM[n] = nth bit produced;
  - ROM[0..15] = 0,0,0,0,1,1,1,0,1,1,1,1,0,0,1,0;
  - ROM[127] = 0.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle -> empty=1, full=0, data_count=0, dout=0. Assert rd_en while empty -> dout stays 0, count stays 0.
- Write 0x0_0000_0001..0x0_0000_0003, then rd_en for 3 cycles -> dout = 1, 2, 3, each one cycle after its rd_en; empty=1 after the third read; bits [33:32] preserved (test with din=0x3_DEADBEEF).
- Write 64 words -> full=1, data_count=64. A 65th write is dropped. Read 64 -> exact input order, then empty=1.
- Fill to 10 words, then wr_en and rd_en together for 100 cycles -> data_count stays 10, order preserved across pointer wrap. Simultaneous wr/rd when empty -> count becomes 1. Simultaneous wr/rd when full -> count becomes 63.
- Apply rst=0 with 20 words stored and wr_en=1 -> next cycle empty=1, count=0, dout=0; a following read returns only newly written data.
- Sweep pilot_addr 0..127 -> pilot_dout one cycle later matches the scrambler sequence (first 8: 0,0,0,0,1,1,1,0). Addr 127 -> 0. During rst=0 -> pilot_dout=0.

Source files
------------

// File: rtl/pilot_insert_buffer.sv
// Input-side storage for OFDM pilot insertion: a synchronous standard-mode FIFO
// of {tlast, symb_last, IQ} words plus a 127-entry pilot-polarity ROM.
module pilot_insert_buffer #(
  parameter int DATA_WIDTH = 34,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  data_count,
  input  logic [6:0]            pilot_addr,
  output logic                  pilot_dout
);

  localparam int AW = $clog2(DEPTH);

  // ROM[n] is the nth output bit of the x^7+x^4+1 scrambler seeded all-ones;
  // entry 127 stays 0.
  function automatic logic [127:0] gen_pilot_rom();
    logic [6:0]   s;
    logic         b;
    logic [127:0] r;
    s = '1;
    r = '0;
    for (int unsigned n = 0; n < 127; n++) begin
      b    = s[6] ^ s[3];
      s    = {s[5:0], b};
      r[n] = b;
    end
    return r;
  endfunction

  localparam logic [127:0] PILOT_ROM = gen_pilot_rom();

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Flags are registered, so the accept decisions depend only on state.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    cnt_next = data_count;
    if (do_wr && !do_rd) cnt_next = data_count + 1'b1;
    else if (do_rd && !do_wr) cnt_next = data_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      dout       <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      data_count <= cnt_next;
      full       <= (cnt_next == CNT_WIDTH'(DEPTH));
      empty      <= (cnt_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pilot_dout <= 1'b0;
    else      pilot_dout <= PILOT_ROM[pilot_addr];
  end

endmodule

// File: tb/tb_pilot_insert_buffer.sv
// Self-checking bench for pilot_insert_buffer: queue-based FIFO scoreboard
// plus a scrambler reference for the pilot ROM.
module tb_pilot_insert_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [33:0] dout;
  logic        full;
  logic        empty;
  logic [6:0]  data_count;
  logic [6:0]  pilot_addr;
  logic        pilot_dout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [33:0] sb[$];
  logic [33:0] exp_dout;

  always #5 clk = ~clk;

  pilot_insert_buffer #(.DATA_WIDTH(34), .DEPTH(64), .CNT_WIDTH(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .pilot_addr (pilot_addr),
    .pilot_dout (pilot_dout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock of FIFO traffic; the scoreboard decides what the DUT must accept.
  task automatic cycle(input logic wr, input logic rd, input logic [33:0] d);
    logic do_wr;
    logic do_rd;
    do_wr = wr && (sb.size() < 64);
    do_rd = rd && (sb.size() > 0);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    if (do_rd) exp_dout = sb.pop_front();
    if (do_wr) sb.push_back(d);
    @(posedge clk);
    #1;
    check("dout",  dout, exp_dout);
    check("count", data_count, sb.size());
    check("full",  full,  sb.size() == 64);
    check("empty", empty, sb.size() == 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic wr);
    rst   = 1'b0;
    wr_en = wr;
    rd_en = 1'b0;
    din   = 34'h1_2345_6789;
    pilot_addr = 7'd4;
    @(posedge clk);
    #1;
    sb.delete();
    exp_dout = '0;
    rst   = 1'b1;
    wr_en = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full",  full, 0);
    check("rst_count", data_count, 0);
    check("rst_dout",  dout, 0);
    check("rst_pilot", pilot_dout, 0);
  endtask

  initial begin
    logic [6:0]   s;
    logic         b;
    logic [127:0] rom_ref;
    logic [15:0]  first16;

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0; pilot_addr = '0;
    exp_dout = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    repeat (2) cycle(1'b0, 1'b0, '0);

    // read while empty is ignored
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);

    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 34'(i));
    repeat (3) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 34'h3_DEAD_BEEF);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);

    // fill to full, one dropped write, then drain in order
    for (int i = 0; i < 65; i++) cycle(1'b1, 1'b0, {$urandom_range(3, 0), $urandom()});
    repeat (64) cycle(1'b0, 1'b1, '0);

    // steady state across pointer wrap
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, {2'b01, $urandom()});
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, {$urandom_range(3, 0), $urandom()});
    repeat (10) cycle(1'b0, 1'b1, '0);

    // simultaneous when empty: write only
    cycle(1'b1, 1'b1, 34'h2_0000_00AA);
    cycle(1'b0, 1'b1, '0);

    // simultaneous when full: read only
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 34'(i + 100));
    cycle(1'b1, 1'b1, 34'h3_FFFF_FFFF);
    repeat (63) cycle(1'b0, 1'b1, '0);

    // reset mid-operation with a write pending
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 34'(i + 500));
    cycle(1'b0, 1'b1, '0);
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 34'h1_0000_0777);
    cycle(1'b1, 1'b0, 34'h0_0000_0888);
    repeat (3) cycle(1'b0, 1'b1, '0);

    // pilot ROM reference: scrambler x^7+x^4+1 seeded all-ones
    s = 7'h7F;
    rom_ref = '0;
    for (int n = 0; n < 127; n++) begin
      b = s[6] ^ s[3];
      s = {s[5:0], b};
      rom_ref[n] = b;
    end
    first16 = 16'b0100_1111_0111_0000;
    for (int a = 0; a < 128; a++) begin
      pilot_addr = 7'(a);
      @(posedge clk);
      #1;
      check("pilot", pilot_dout, (a < 16) ? first16[a] : rom_ref[a]);
    end

    do_reset(1'b0);
    pilot_addr = 7'd5;
    @(posedge clk);
    #1;
    check("pilot_after_rst", pilot_dout, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
